pipelined_add_sub: RTL

Parametrised, pipelined two's-complement adder/subtractor that splits a WIDTH-bit operation into STAGES equal carry-chained slices, one slice per clock.
- Successor to the combinational ripple-carry adder: scales to wide operands and higher clock rates.
- Adds subtract mode, carry-out, signed overflow and a valid/ready handshake with backpressure.
- Sits between operand sources and the datapath result bus in the arithmetic unit.

---
 rtl/pipelined_add_sub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined two's-complement adder/subtractor with valid/ready flow control
module pipelined_add_sub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   // Each stage resolves one CHUNK-bit slice of the operation.
   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Per-stage registers. acc_q[k] holds result slices 0..k in its low bits
   // and the not-yet-added slices of A in its high bits, so the finished
   // slices travel down the pipe alongside the pending operand slices.
   // beff_q[k] carries the inverted-or-not B for the slices still to be added.
   logic [WIDTH-1:0] acc_q  [STAGES];
   logic [WIDTH-1:0] beff_q [STAGES];
   logic             cry_q  [STAGES];
   logic             vld_q  [STAGES];
   logic             ovf_q;

   // Next-state values for every stage.
   logic [WIDTH-1:0] acc_d  [STAGES];
   logic [WIDTH-1:0] beff_d [STAGES];
   logic             cry_d  [STAGES];
   logic             vld_d  [STAGES];
   logic             ovf_d;

   // Working values for the slice adder of the stage being evaluated.
   logic [WIDTH-1:0] src_acc;
   logic [WIDTH-1:0] src_beff;
   logic             src_cin;
   logic             src_vld;
   logic [CHUNK:0]   slice_sum;

   logic             stall;

   // The whole pipe freezes only when a real result is waiting on the consumer;
   // a bubble at the output never blocks the stages behind it.
   assign stall     = vld_q[LAST] && !out_ready;
   assign in_ready  = !stall;

   assign out_valid = vld_q[LAST];
   assign sum       = acc_q[LAST];
   assign cout      = cry_q[LAST];
   assign overflow  = ovf_q;

   // Slice adders: stage k adds slice k of A and effective B plus the carry
   // handed down from stage k-1 (stage 0 takes the operands straight from
   // the input port, with sub as its carry-in to finish the negation of B).
   always_comb begin
      src_acc   = '0;
      src_beff  = '0;
      src_cin   = 1'b0;
      src_vld   = 1'b0;
      slice_sum = '0;
      ovf_d     = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            src_acc  = a;
            src_beff = b ^ {WIDTH{sub}};
            src_cin  = sub;
            src_vld  = in_valid;
         end else begin
            src_acc  = acc_q[(k > 0) ? k - 1 : 0];
            src_beff = beff_q[(k > 0) ? k - 1 : 0];
            src_cin  = cry_q[(k > 0) ? k - 1 : 0];
            src_vld  = vld_q[(k > 0) ? k - 1 : 0];
         end

         slice_sum = {1'b0, src_acc[k*CHUNK +: CHUNK]}
                   + {1'b0, src_beff[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_cin};

         acc_d[k]                    = src_acc;
         acc_d[k][k*CHUNK +: CHUNK]  = slice_sum[CHUNK-1:0];
         beff_d[k]                   = src_beff;
         cry_d[k]                    = slice_sum[CHUNK];
         vld_d[k]                    = src_vld;

         // Only the last stage sees the MSB. The carry into the MSB is
         // recovered as a ^ b ^ sum at that bit, then compared to carry-out.
         if (k == LAST) begin
            ovf_d = src_acc[WIDTH-1] ^ src_beff[WIDTH-1]
                  ^ slice_sum[CHUNK-1] ^ slice_sum[CHUNK];
         end
      end
   end

   // Stage registers: cleared at once on reset, held together on stall,
   // otherwise all stages (bubbles included) advance one slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            acc_q[k]  <= '0;
            beff_q[k] <= '0;
            cry_q[k]  <= 1'b0;
            vld_q[k]  <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            acc_q[k]  <= acc_d[k];
            beff_q[k] <= beff_d[k];
            cry_q[k]  <= cry_d[k];
            vld_q[k]  <= vld_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

endmodule
